n64_vi_txgen: RTL and testbench

Transmit side of the N64 digital video bus: generates the multiplexed VI stream (nVDSYNC plus 7-bit VD) that the PPU front end (vinfo extraction, deblur, demux) consumes. It is used as a built-in pattern source for bring-up and as the stimulus generator in PPU benches. It replaces the console RCP on the VCLK domain and produces sync, clamp and RGB words from internal timing counters and a selectable test pattern.

---
 rtl/n64_vi_txgen.sv | 145 ++++++++++++++
 tb/tb_n64_vi_txgen.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/n64_vi_txgen.sv
// n64_vi_txgen: N64 VI bus transmitter (nVDSYNC + 7-bit VD) with internal timing and test patterns.
// One sync word and three colour words per pixel.
module n64_vi_txgen #(
   parameter int H_TOTAL     = 773,
   parameter int H_SYNC      = 57,
   parameter int CLAMP_START = 65,
   parameter int CLAMP_LEN   = 28,
   parameter int H_ACT_START = 120,
   parameter int H_ACT_LEN   = 640,
   parameter int V_TOTAL     = 263,
   parameter int V_SYNC      = 3,
   parameter int V_ACT_START = 20,
   parameter int V_ACT_LEN   = 240,
   parameter int BAR_W       = 80
) (
   input  logic        VCLK,
   input  logic        VRST,
   input  logic        enable,
   input  logic        interlace_i,
   input  logic [1:0]  pattern_i,
   input  logic [20:0] solid_rgb_i,
   output logic        nVDSYNC,
   output logic [6:0]  VD_o,
   output logic        frame_start_o,
   output logic        field_o
);
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam int BW = $clog2(BAR_W + 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [1:0]    phase_q, phase_d;
   logic [HW-1:0] h_q, h_d, h_nx;
   logic [VW-1:0] v_q, v_d;
   logic          field_q, field_d;
   logic          il_q, il_d;
   logic [1:0]    pat_q, pat_d;
   logic [20:0]   solid_q, solid_d;
   logic [BW-1:0] bar_px_q, bar_px_d;
   logic [2:0]    bar_idx_q, bar_idx_d;
   logic          nvd_q, nvd_d, fs_q, fs_d, fld_q, fld_d;
   logic [6:0]    vd_q, vd_d;

   logic go, field_start, h_last, v_last, field_end, stop, lat;
   logic n_hs, n_cl, n_vs, n_cs, active, chk;
   logic [6:0]  x7;
   logic [4:0]  y5;
   logic [2:0]  bar_rgb;
   logic [20:0] pix;
   logic [6:0]  word;

   always_comb begin
      go          = (state_q == RUN) || enable;
      field_start = phase_q == 2'd0 && h_q == '0 && v_q == '0;
      h_last      = h_q == HW'(H_TOTAL - 1);
      v_last      = v_q == (field_q ? VW'(V_TOTAL - 2) : VW'(V_TOTAL - 1));
      field_end   = phase_q == 2'd3 && h_last && v_last;
      stop        = state_q == RUN && field_end && !enable;
      lat         = go && field_start;
      h_nx        = h_last ? '0 : h_q + 1'b1;
      n_hs        = h_q >= HW'(H_SYNC);
      n_cl        = !(h_q >= HW'(CLAMP_START) && h_q < HW'(CLAMP_START + CLAMP_LEN));
      // field 1 vsync is offset by half a line to give the interlace half-line shift
      n_vs        = field_q ? !((v_q != '0 || h_q >= HW'(H_TOTAL / 2)) &&
                               (v_q < VW'(V_SYNC) || (v_q == VW'(V_SYNC) && h_q < HW'(H_TOTAL / 2))))
                            : v_q >= VW'(V_SYNC);
      n_cs        = n_vs ? n_hs : !n_hs;
      active      = h_q >= HW'(H_ACT_START) && h_q < HW'(H_ACT_START + H_ACT_LEN) &&
                    v_q >= VW'(V_ACT_START) && v_q < VW'(V_ACT_START + V_ACT_LEN);
      x7          = 7'(h_q - HW'(H_ACT_START));
      y5          = 5'(v_q) - 5'(V_ACT_START);
      chk         = x7[4] ^ (y5 > 5'd15);
      bar_rgb     = {~bar_idx_q[1], ~bar_idx_q[2], ~bar_idx_q[0]};
      pix         = !active          ? 21'd0 :
                    pat_q == 2'b00   ? {{7{bar_rgb[2]}}, {7{bar_rgb[1]}}, {7{bar_rgb[0]}}} :
                    pat_q == 2'b01   ? {21{chk}} :
                    pat_q == 2'b10   ? {3{x7}} : solid_q;
      word        = phase_q == 2'd0 ? {3'b000, n_vs, n_cl, n_hs, n_cs} :
                    phase_q == 2'd1 ? pix[20:14] :
                    phase_q == 2'd2 ? pix[13:7] : pix[6:0];
      state_d     = state_q == RUN ? (stop ? IDLE : RUN) : (enable ? RUN : IDLE);
      phase_d     = go ? phase_q + 2'd1 : 2'd0;
      h_d         = !go ? '0 : phase_q == 2'd3 ? h_nx : h_q;
      v_d         = !go ? '0 : (phase_q == 2'd3 && h_last) ? (v_last ? '0 : v_q + 1'b1) : v_q;
      field_d     = (!go || stop) ? 1'b0 : field_end ? (il_q & ~field_q) : field_q;
      il_d        = lat ? interlace_i : il_q;
      pat_d       = lat ? pattern_i : pat_q;
      solid_d     = lat ? solid_rgb_i : solid_q;
      bar_px_d    = bar_px_q;
      bar_idx_d   = bar_idx_q;
      if (!go) begin
         bar_px_d  = '0;
         bar_idx_d = '0;
      end else if (phase_q == 2'd3) begin
         bar_px_d  = (h_nx == HW'(H_ACT_START) || bar_px_q == BW'(BAR_W - 1)) ? '0 : bar_px_q + 1'b1;
         bar_idx_d = h_nx == HW'(H_ACT_START) ? 3'd0 :
                     (bar_px_q == BW'(BAR_W - 1) && bar_idx_q != 3'd7) ? bar_idx_q + 3'd1 : bar_idx_q;
      end
      nvd_d       = go ? phase_q != 2'd0 : 1'b1;
      vd_d        = go ? word : 7'd0;
      fs_d        = go && field_start;
      fld_d       = go && field_q;
   end

   always_ff @(posedge VCLK or posedge VRST) begin
      if (VRST) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         h_q       <= '0;
         v_q       <= '0;
         field_q   <= 1'b0;
         il_q      <= 1'b0;
         pat_q     <= '0;
         solid_q   <= '0;
         bar_px_q  <= '0;
         bar_idx_q <= '0;
         nvd_q     <= 1'b1;
         vd_q      <= '0;
         fs_q      <= 1'b0;
         fld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         h_q       <= h_d;
         v_q       <= v_d;
         field_q   <= field_d;
         il_q      <= il_d;
         pat_q     <= pat_d;
         solid_q   <= solid_d;
         bar_px_q  <= bar_px_d;
         bar_idx_q <= bar_idx_d;
         nvd_q     <= nvd_d;
         vd_q      <= vd_d;
         fs_q      <= fs_d;
         fld_q     <= fld_d;
      end
   end

   assign nVDSYNC       = nvd_q;
   assign VD_o          = vd_q;
   assign frame_start_o = fs_q;
   assign field_o       = fld_q;
endmodule

// File: tb/tb_n64_vi_txgen.sv
// tb_n64_vi_txgen: scoreboard bench for n64_vi_txgen using reduced timing parameters.
// Line = 48 px (192 VCLK), field 0 = 14 lines (2688 VCLK), field 1 = 13 lines (2496 VCLK).
module tb_n64_vi_txgen;
   logic        VCLK = 1'b0;
   logic        VRST;
   logic        enable;
   logic        interlace_i;
   logic [1:0]  pattern_i;
   logic [20:0] solid_rgb_i;
   logic        nVDSYNC;
   logic [6:0]  VD_o;
   logic        frame_start_o;
   logic        field_o;

   int checks = 0;
   int failures = 0;
   int cyc = -1;

   typedef struct {
      int         c;
      string      name;
      logic       nv;
      logic [6:0] vd;
      logic       fs;
      logic       fld;
   } exp_t;
   exp_t q[$];

   n64_vi_txgen #(
      .H_TOTAL(48), .H_SYNC(4), .CLAMP_START(6), .CLAMP_LEN(3),
      .H_ACT_START(10), .H_ACT_LEN(30), .V_TOTAL(14), .V_SYNC(3),
      .V_ACT_START(4), .V_ACT_LEN(6), .BAR_W(3)
   ) dut (
      .VCLK(VCLK), .VRST(VRST), .enable(enable), .interlace_i(interlace_i),
      .pattern_i(pattern_i), .solid_rgb_i(solid_rgb_i), .nVDSYNC(nVDSYNC),
      .VD_o(VD_o), .frame_start_o(frame_start_o), .field_o(field_o)
   );

   always #5 VCLK = ~VCLK;

   always @(posedge VCLK) if (!VRST) cyc <= cyc + 1;

   task automatic push(input int c, input string n, input logic nv, input logic [6:0] vd,
                       input logic fs, input logic fld);
      exp_t e;
      e.c = c; e.name = n; e.nv = nv; e.vd = vd; e.fs = fs; e.fld = fld;
      q.push_back(e);
   endtask

   task automatic chk(input string n, input logic nv, input logic [6:0] vd, input logic fs,
                      input logic fld);
      checks++;
      if ({nVDSYNC, VD_o, frame_start_o, field_o} !== {nv, vd, fs, fld}) begin
         failures++;
         $display("FAIL %s @cyc %0d: got nv=%b vd=%h fs=%b fld=%b, want nv=%b vd=%h fs=%b fld=%b",
                  n, cyc, nVDSYNC, VD_o, frame_start_o, field_o, nv, vd, fs, fld);
      end
   endtask

   always @(negedge VCLK) begin
      while (q.size() > 0 && q[0].c <= cyc) begin
         if (q[0].c < cyc) begin
            checks++;
            failures++;
            $display("FAIL %s: missed expected cycle %0d (now %0d)", q[0].name, q[0].c, cyc);
         end else
            chk(q[0].name, q[0].nv, q[0].vd, q[0].fs, q[0].fld);
         q.delete(0);
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge VCLK);
   endtask

   initial begin
      VRST = 1'b1; enable = 1'b1; interlace_i = 1'b0; pattern_i = 2'b00; solid_rgb_i = '0;
      // field 0: bars, progressive
      push(0,    "first_sync",   0, 7'h05, 1, 0);
      push(1,    "first_R",      1, 7'h00, 0, 0);
      push(2,    "first_G",      1, 7'h00, 0, 0);
      push(3,    "first_B",      1, 7'h00, 0, 0);
      push(4,    "h1_sync",      0, 7'h05, 0, 0);
      push(16,   "hsync_end",    0, 7'h06, 0, 0);
      push(24,   "clamp_start",  0, 7'h02, 0, 0);
      push(32,   "clamp_last",   0, 7'h02, 0, 0);
      push(36,   "clamp_end",    0, 7'h06, 0, 0);
      push(576,  "vsync_end",    0, 7'h0C, 0, 0);
      push(592,  "csync_follow", 0, 7'h0F, 0, 0);
      push(805,  "pre_active_R", 1, 7'h00, 0, 0);
      push(809,  "white_R",      1, 7'h7F, 0, 0);
      push(810,  "white_G",      1, 7'h7F, 0, 0);
      push(811,  "white_B",      1, 7'h7F, 0, 0);
      push(821,  "yellow_R",     1, 7'h7F, 0, 0);
      push(822,  "yellow_G",     1, 7'h7F, 0, 0);
      push(823,  "yellow_B",     1, 7'h00, 0, 0);
      push(881,  "blue_R",       1, 7'h00, 0, 0);
      push(883,  "blue_B",       1, 7'h7F, 0, 0);
      push(917,  "bar_sat_R",    1, 7'h00, 0, 0);
      push(1769, "held_bars_R",  1, 7'h7F, 0, 0);
      push(1961, "below_act_R",  1, 7'h00, 0, 0);
      // field 2: solid latched at its start
      push(2688, "field2_start", 0, 7'h05, 1, 0);
      push(3493, "solid_out_R",  1, 7'h00, 0, 0);
      push(3497, "solid_R",      1, 7'h11, 0, 0);
      push(3498, "solid_G",      1, 7'h22, 0, 0);
      push(3499, "solid_B",      1, 7'h33, 0, 0);
      push(3648, "v5_csync",     0, 7'h0C, 0, 0);
      // field 3: checker, interlace latched
      push(5376, "field3_start", 0, 7'h05, 1, 0);
      push(6185, "chk_black_R",  1, 7'h00, 0, 0);
      push(6249, "chk_white_R",  1, 7'h7F, 0, 0);
      // field 4: odd field, gradient
      push(8064, "field1_start", 0, 7'h0C, 1, 1);
      push(8156, "f1_pre_vs",    0, 7'h0F, 0, 1);
      push(8160, "f1_vs_low",    0, 7'h06, 0, 1);
      push(8732, "f1_v3_low",    0, 7'h06, 0, 1);
      push(8736, "f1_vs_high",   0, 7'h0F, 0, 1);
      push(8893, "grad_R",       1, 7'h05, 0, 1);
      push(10559,"f1_last",      1, 7'h00, 0, 1);
      // field 5: enable dropped mid-field
      push(10560,"field5_start", 0, 7'h05, 1, 0);
      push(13056,"no_truncate",  0, 7'h0C, 0, 0);
      push(13247,"last_word",    1, 7'h00, 0, 0);
      push(13248,"idle",         1, 7'h00, 0, 0);
      push(13299,"idle_late",    1, 7'h00, 0, 0);
      push(13300,"restart",      0, 7'h05, 1, 0);
      push(13301,"restart_R",    1, 7'h00, 0, 0);
      repeat (3) @(negedge VCLK);
      chk("reset_state", 1, 7'h00, 0, 0);
      VRST = 1'b0;
      wait_cyc(1000);
      pattern_i = 2'b11; solid_rgb_i = {7'h11, 7'h22, 7'h33};
      wait_cyc(3000);
      interlace_i = 1'b1; pattern_i = 2'b01;
      wait_cyc(6000);
      pattern_i = 2'b10;
      wait_cyc(11520);
      enable = 1'b0;
      wait_cyc(13299);
      enable = 1'b1;
      wait_cyc(13312);
      #1 VRST = 1'b1;
      #1 chk("async_reset", 1, 7'h00, 0, 0);
      repeat (2) @(negedge VCLK);
      while (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL %s: expected cycle %0d never reached", q[0].name, q[0].c);
         q.delete(0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
